iq_sincos: RTL and testbench
============================

Name: iq_sincos

Overview:
- Per-sample I/Q mixing core for the direct-DAC IQ modulator.
- Takes a 5-bit carrier phase index (32 steps per carrier cycle) and signed 4-bit I and Q symbols.
- Produces registered products I·cos(phase) and Q·sin(phase) as signed 9-bit values.
- The parent forms the DAC word as 512 + icos − qsin; output scaling guarantees that sum stays within 0..1023.

Parameters:
- None configurable. Fixed constants live in the package listed under Decomposition: PHASE_W=5, IQ_W=4, LUT_AMP=31, OUT_W=9.

Ports:
- clk   in   1  rising-edge clock for all state.
- rst   in   1  synchronous, active-high reset.
- icos  out  9  signed; registered i × cos(2π·tpos/32) in LUT units.
- qsin  out  9  signed; registered q × sin(2π·tpos/32) in LUT units.
- tpos  in   5  unsigned phase index 0..31; wraps naturally, 31→0.
- i     in   4  signed two's complement I symbol, −8..+7.
- q     in   4  signed two's complement Q symbol, −8..+7.

Behaviour:
- Sine table S[k] = round(31·sin(2πk/32)), k = 0..31.
  - Quarter-wave values, k = 0..8: 0, 6, 12, 17, 22, 26, 29, 30, 31.
  - k = 9..16: S[k] = S[16−k].
  - k = 17..31: S[k] = −S[k−16].
- Cosine C[k] = S[(k+8) mod 32]; this is the 5-bit wraparound add of 8.
- Arithmetic:
  - Signed 4-bit × signed 6-bit multiply into a 9-bit signed result.
  - Product range −248..+248, so no saturation is needed and none is performed.
  - Full-scale DAC excursion is 512 ± 496.
- Timing:
  - One-cycle latency.
  - On each rising clk edge with rst=0: icos ← i·C[tpos] and qsin ← q·S[tpos], using i, q and tpos sampled at that same edge.
  - Outputs are held between edges.
  - Exact LUT values are required at every phase. No interpolation, no dithering.
- Reset:
  - On a rising edge with rst=1: icos=0 and qsin=0.
  - Reset overrides any input change on that edge.
  - The first valid product appears on the first edge after rst deasserts.
  - Mid-stream reset zeroes the outputs on that edge and discards the in-flight product.
- No handshake, no enable: the block computes on every cycle.
- Boundary cases:
  - tpos 31→0 wrap: no discontinuity beyond the table step.
  - i or q = −8: the product at peak is −8·±31 = ∓248 exactly.
  - i or q = 0: output is 0 at every phase.
- X on inputs need not be handled; the parent always drives defined values.

Decomposition:
- Package iq_pkg holds:
  - PHASE_W, IQ_W, LUT_AMP, OUT_W;
  - the 9-entry quarter-wave constant array;
  - typedefs phase_t (5b), iq_t (signed 4b), lut_t (signed 6b), prod_t (signed 9b).
- One sub-module, sin_qrom:
  - combinational quarter-wave ROM with symmetry/sign folding, phase_t in, lut_t out;
  - instantiated twice, once with tpos and once with tpos+8.
- Multiplies and output registers stay in iq_sincos.

Test Plan:
- Reset: hold rst=1 with i=7, q=7, tpos=2 → icos=0, qsin=0. Release rst → next edge gives icos=7·29=203 and qsin=7·12=84.
- Peak cosine: tpos=0, i=7, q=7 → icos=217, qsin=0. tpos=16, i=5, q=5 → icos=−155, qsin=0.
- Peak sine, negative extreme: tpos=8, i=−8, q=−8 → icos=0, qsin=−248. tpos=24, i=1, q=1 → icos=0, qsin=−31.
- Mid phase, mixed signs: tpos=4, i=3, q=−2 → icos=66, qsin=−44. tpos=20, i=−1, q=−1 → icos=22, qsin=22.
- Full sweep: i=q=1, tpos stepping by 2 from 0 through the 30→0 wrap. Check every output against the S/C tables with 1-cycle latency, then repeat with i=q=−8. Check that 512+icos−qsin stays within 16..1008.
- Latency and mid-stream reset: change i from 7 to −3 at tpos=0 → the old product persists until the next edge. Assert rst for one cycle mid-sweep → zeros on that edge only, correct products resume on the following edge.

Source files
------------

// File: rtl/iq_pkg.sv
// iq_pkg: shared constants and types for the I/Q mixing core.
//   PHASE_W / IQ_W / LUT_AMP / OUT_W : fixed widths and table amplitude
//   QW_TABLE : quarter-wave sine magnitudes round(31*sin(2*pi*k/32)), k=0..8
//   phase_t / iq_t / lut_t / prod_t  : phase index, symbol, table value, product
package iq_pkg;

  localparam int PHASE_W = 5;
  localparam int IQ_W    = 4;
  localparam int LUT_AMP = 31;
  localparam int OUT_W   = 9;

  typedef logic        [PHASE_W-1:0] phase_t;
  typedef logic signed [IQ_W-1:0]    iq_t;
  typedef logic signed [5:0]         lut_t;
  typedef logic signed [OUT_W-1:0]   prod_t;

  // Magnitudes only; sign and mirroring are applied by sin_qrom.
  localparam logic [5:0] QW_TABLE [0:8] = '{
    6'd0, 6'd6, 6'd12, 6'd17, 6'd22, 6'd26, 6'd29, 6'd30, 6'd31
  };

endpackage

// File: rtl/iq_sincos_sin_qrom.sv
// sin_qrom: combinational 32-step sine ROM built from a 9-entry quarter wave.
//   i_phase : phase index 0..31
//   o_val   : signed sine value in LUT units (-31..+31)
module sin_qrom
  import iq_pkg::*;
(
  input  logic [4:0] i_phase,
  output logic [5:0] o_val
);

  logic [3:0] w_half;   // position within the current half cycle, 0..15
  logic [3:0] w_idx;    // mirrored quarter-wave index, always 0..8
  logic [5:0] w_mag;

  assign w_half = i_phase[3:0];

  // Second quarter of each half mirrors the first: S[k] = S[16-k].
  always_comb begin
    w_idx = w_half;
    if (w_half > 4'd8) begin
      w_idx = 4'd0 - w_half;  // 16 - w_half modulo 16
    end
  end

  always_comb begin
    w_mag = 6'd0;
    if (w_idx <= 4'd8) begin
      w_mag = QW_TABLE[w_idx];
    end
  end

  // Second half of the cycle is the negated first half.
  assign o_val = i_phase[4] ? (6'd0 - w_mag) : w_mag;

endmodule

// File: rtl/iq_sincos.sv
// iq_sincos: per-sample I/Q mixer, one-cycle latency, no enable.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, zeroes both outputs
//   tpos : carrier phase index 0..31
//   i, q : signed 4-bit symbols
//   icos : registered i * cos(2*pi*tpos/32), signed 9-bit LUT units
//   qsin : registered q * sin(2*pi*tpos/32), signed 9-bit LUT units
// Interface has no valid/ready: every edge out of reset captures a new
// product from the inputs present at that edge.
module iq_sincos
  import iq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] tpos,
  input  logic [3:0] i,
  input  logic [3:0] q,
  output logic [8:0] icos,
  output logic [8:0] qsin
);

  logic [4:0]        w_cos_phase;
  logic [5:0]        w_sin_val;
  logic [5:0]        w_cos_val;
  logic signed [8:0] w_i_ext;
  logic signed [8:0] w_q_ext;
  logic signed [8:0] w_sin_ext;
  logic signed [8:0] w_cos_ext;
  logic signed [8:0] w_icos;
  logic signed [8:0] w_qsin;
  logic [8:0]        r_icos;
  logic [8:0]        r_qsin;

  // cos(k) = sin(k+8); the 5-bit add wraps naturally.
  assign w_cos_phase = tpos + 5'd8;

  sin_qrom u_sin (
    .i_phase (tpos),
    .o_val   (w_sin_val)
  );

  sin_qrom u_cos (
    .i_phase (w_cos_phase),
    .o_val   (w_cos_val)
  );

  // Sign-extend to the product width; |product| <= 248 so 9 bits is exact.
  assign w_i_ext   = {{5{i[3]}}, i};
  assign w_q_ext   = {{5{q[3]}}, q};
  assign w_sin_ext = {{3{w_sin_val[5]}}, w_sin_val};
  assign w_cos_ext = {{3{w_cos_val[5]}}, w_cos_val};
  assign w_icos    = w_i_ext * w_cos_ext;
  assign w_qsin    = w_q_ext * w_sin_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_icos <= 9'd0;
      r_qsin <= 9'd0;
    end else begin
      r_icos <= w_icos;
      r_qsin <= w_qsin;
    end
  end

  assign icos = r_icos;
  assign qsin = r_qsin;

endmodule

// File: tb/tb_iq_sincos.sv
module tb_iq_sincos;

  logic       clk;
  logic       rst;
  logic [4:0] tpos;
  logic [3:0] i;
  logic [3:0] q;
  logic [8:0] icos;
  logic [8:0] qsin;

  int checks;
  int failures;

  // Full 32-entry reference sine table, written out by hand.
  int s_tab [0:31] = '{
      0,   6,  12,  17,  22,  26,  29,  30,  31,  30,  29,  26,  22,  17,   6 + 6,   6,
      0,  -6, -12, -17, -22, -26, -29, -30, -31, -30, -29, -26, -22, -17, -12,  -6
  };

  typedef struct {
    string name;
    int    tpos;
    int    i;
    int    q;
    int    exp_icos;
    int    exp_qsin;
  } vec_t;

  vec_t vecs [0:5];

  iq_sincos dut (
    .clk  (clk),
    .rst  (rst),
    .tpos (tpos),
    .i    (i),
    .q    (q),
    .icos (icos),
    .qsin (qsin)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cos_ref(input int k);
    return s_tab[(k + 8) % 32];
  endfunction

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int t, input int iv, input int qv);
    tpos = 5'(t);
    i    = 4'(iv);
    q    = 4'(qv);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int ei, input int eq);
    check({name, ".icos"}, int'($signed(icos)), ei);
    check({name, ".qsin"}, int'($signed(qsin)), eq);
  endtask

  task automatic sweep(input int amp);
    int dac;
    for (int t = 0; t <= 32; t += 2) begin
      drive(t % 32, amp, amp);
      step();
      check_out($sformatf("sweep%0d_t%0d", amp, t % 32),
                amp * cos_ref(t % 32), amp * s_tab[t % 32]);
      dac = 512 + int'($signed(icos)) - int'($signed(qsin));
      checks++;
      if (dac < 16 || dac > 1008) begin
        failures++;
        $display("FAIL dac_range_t%0d: got %0d expected 16..1008", t % 32, dac);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{"peak_cos0",  0,  7,  7,  217,    0};
    vecs[1] = '{"peak_cos16", 16, 5,  5, -155,    0};
    vecs[2] = '{"neg_ext8",   8, -8, -8,    0, -248};
    vecs[3] = '{"sin24",      24, 1,  1,    0,  -31};
    vecs[4] = '{"mid4",       4,  3, -2,   66,  -44};
    vecs[5] = '{"mid20",      20, -1, -1,  22,   22};

    // Reset holds outputs at zero despite live inputs.
    rst = 1'b1;
    drive(2, 7, 7);
    step();
    step();
    check_out("reset", 0, 0);
    rst = 1'b0;
    step();
    check_out("first_after_reset", 203, 84);

    // Directed vectors.
    for (int n = 0; n < 6; n++) begin
      drive(vecs[n].tpos, vecs[n].i, vecs[n].q);
      step();
      check_out(vecs[n].name, vecs[n].exp_icos, vecs[n].exp_qsin);
    end

    // Sweeps through the 30->0 wrap.
    sweep(1);
    sweep(-8);

    // Zero symbol gives zero at several phases.
    for (int t = 0; t < 32; t += 5) begin
      drive(t, 0, 0);
      step();
      check_out($sformatf("zero_t%0d", t), 0, 0);
    end

    // Latency: input change between edges does not reach the outputs.
    drive(0, 7, 7);
    step();
    check_out("lat_before", 217, 0);
    drive(0, -3, 7);
    #2;
    check_out("lat_hold", 217, 0);
    step();
    check_out("lat_after", -93, 0);

    // Mid-stream reset: zeros on that edge only.
    drive(4, 3, -2);
    step();
    check_out("mid_t4", 66, -44);
    drive(6, 3, -2);
    step();
    check_out("mid_t6", 3 * cos_ref(6), -2 * s_tab[6]);
    rst = 1'b1;
    drive(8, 3, -2);
    step();
    check_out("mid_rst", 0, 0);
    rst = 1'b0;
    drive(10, 3, -2);
    step();
    check_out("mid_resume", -36, -58);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
